// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one bit per clock.
// A start pulse in IDLE captures bin; WIDTH cycles later the packed BCD result
// and overflow flag are written together, with a one-cycle done pulse.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   start  - conversion request, sampled only in IDLE
//   bin    - unsigned binary input, captured when start is accepted
//   busy   - high while a conversion is in progress
//   done   - one-cycle pulse when bcd/ovf are updated
//   bcd    - packed BCD result (digit 0 in [3:0]), held between conversions
//   ovf    - any digit at index >= SHOW of the latest result is nonzero
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5,
    parameter int unsigned SHOW   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  sh, sh_nxt;
    logic [BCD_W-1:0]  scratch, scratch_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              busy_nxt, done_nxt, ovf_nxt;
    logic [BCD_W-1:0]  bcd_nxt;

    logic [BCD_W-1:0]  adj;
    logic [BCD_W-1:0]  shifted;
    logic              ovf_c;

    // Add-3 correction on every digit in parallel; digits stay <= 9 so no carry
    always_comb begin
        adj = scratch;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Corrected scratch shifted left, taking the next binary MSB into digit 0
    assign shifted = {adj[BCD_W-2:0], sh[WIDTH-1]};

    // Digits above the displayable range
    assign ovf_c = (shifted >> (4 * SHOW)) != '0;

    // Next-state and output logic
    always_comb begin
        state_nxt   = state;
        sh_nxt      = sh;
        scratch_nxt = scratch;
        cnt_nxt     = cnt;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        bcd_nxt     = bcd;
        ovf_nxt     = ovf;

        case (state)
            IDLE: begin
                if (start) begin
                    sh_nxt      = bin;
                    scratch_nxt = '0;
                    cnt_nxt     = '0;
                    busy_nxt    = 1'b1;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                sh_nxt      = sh << 1;
                scratch_nxt = shifted;
                cnt_nxt     = cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    bcd_nxt   = shifted;
                    ovf_nxt   = ovf_c;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sh      <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            sh      <= sh_nxt;
            scratch <= scratch_nxt;
            cnt     <= cnt_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            bcd     <= bcd_nxt;
            ovf     <= ovf_nxt;
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) between the calculator accumulator and the seven-segment display driver. It accepts a 16-bit unsigned accumulator value on a start pulse and produces packed BCD digits. It also flags values too large for the 4-digit display. The display driver reads the held result continuously, so the output register changes only when a conversion completes.

## Interface

Parameters:
- WIDTH, 16, width of the binary input in bits.
- DIGITS, 5, number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH − 1. The default covers 65535.
- SHOW, 4, number of low digits the display can show. Used only for `ovf`.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a conversion of `bin`. Sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value. Captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when `bcd` and `ovf` are updated.
- bcd  output  4*DIGITS  packed BCD result. Digit 0 is bits [3:0]. Held between conversions.
- ovf  output  1  high when any digit at index ≥ SHOW in the latest result is nonzero.

## Operation

- States: IDLE and SHIFT.
- IDLE, start=1 at an edge:
  - Capture `bin` into the shift register.
  - Clear the BCD scratch register and set the bit counter to 0.
  - Set busy=1 and go to SHIFT.
- IDLE, start=0: hold all outputs.
- SHIFT, each edge:
  - In every scratch digit that is ≥ 5, add 3. All digits are corrected in parallel from the pre-edge values.
  - Shift {scratch, shift register} left by 1. The MSB of `bin` enters scratch digit 0 bit 0.
  - Increment the counter.
- SHIFT, on the edge that performs shift number WIDTH (counter = WIDTH−1 before the edge):
  - Write the post-shift scratch value to `bcd`.
  - Compute `ovf` from that same value.
  - Set done=1, busy=0, and go to IDLE.
- start while busy (SHIFT): ignored, not queued. `bin` changes during SHIFT have no effect.
- Scratch digits never exceed 9 after any shift. The correction logic needs no carry between digits.
- `bcd` and `ovf` are written only on the completing edge. They are never exposed mid-conversion.
- Arithmetic is unsigned throughout. No sign handling: the accumulator is treated as unsigned by the display path.

## Timing

- Reset (rst=1 at an edge), from any state:
  - State returns to IDLE.
  - busy=0, done=0, bcd=0, ovf=0, counter=0.
  - Any conversion in progress is aborted with no done pulse.
- rst has priority over start.
- Latency, for start accepted at edge N:
  - busy=1 after edge N.
  - The result appears in `bcd`/`ovf`, with done=1 and busy=0, after edge N+WIDTH. That is 16 cycles at the default.
- done is high for exactly the one cycle following edge N+WIDTH. It is cleared on the next edge unconditionally.
- Back-to-back operation:
  - start=1 during the done cycle is accepted, because the state is already IDLE.
  - Maximum throughput is one conversion per WIDTH+1 cycles.
- start held high continuously: a new conversion starts in every IDLE cycle. Results update every WIDTH+1 cycles.
- start and rst are synchronous single-bit controls. They are expected from the clk domain, e.g. the accumulator update logic.

## Test plan

- Reset, then start with bin=0 -> busy high for 16 cycles; done pulse after edge N+16; bcd=0x00000, ovf=0.
- bin=9999 -> bcd=0x09999, ovf=0. Then bin=10000 back-to-back, with start in the done cycle -> bcd=0x10000, ovf=1, with done 17 cycles after the first done.
- bin=65535 -> bcd=0x65535, ovf=1. Also bin=1234 -> 0x01234 and bin=0x8000 -> 0x32768.
- Start with bin=42, then pulse start with bin=7 at cycle 5 of SHIFT -> exactly one done; bcd=0x00042.
- Start with bin=500, assert rst at cycle 8 of SHIFT -> next cycle busy=0, no done pulse, bcd=0, ovf=0.
- Random sweep of 1000 values -> bcd equals the decimal digits of bin; ovf = (bin > 9999); latency is always 16.
